// File: rtl/writeback_unit.sv
// Writeback stage: accepts retiring instructions, waits for and extends load data,
// and drives the register file write port for one cycle per retiring instruction.
module writeback_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [4:0]      in_rd,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] rddata,
  output logic [4:0]      rdsel,
  output logic            phase_writeback,
  output logic            pending_valid,
  output logic [4:0]      pending_rd,
  output logic            retire,
  output logic            load_fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } state_t;

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_LOAD = 2'b01;

  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] rddata_q, rddata_d;
  logic [4:0]      rdsel_q, rdsel_d;
  logic            wb_q, wb_d;
  logic            retire_q, retire_d;
  logic            fault_q, fault_d;

  logic            accept;
  logic            load_legal;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  assign in_ready = (state_q != WAIT_MEM);
  assign accept   = in_valid & in_ready;

  // Legality is judged on the incoming request so a bad load never enters WAIT_MEM.
  always_comb begin
    case (in_funct3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~in_addr_lo[0];
      3'b010:         load_legal = (in_addr_lo == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_sel = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = (state_q == WAIT_MEM) ? WAIT_MEM : IDLE;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    rddata_d  = rddata_q;
    rdsel_d   = rdsel_q;
    wb_d      = 1'b0;
    retire_d  = 1'b0;
    fault_d   = 1'b0;

    if (state_q == WAIT_MEM && mem_rvalid) begin
      state_d  = WRITE;
      rddata_d = load_data;
      rdsel_d  = rd_q;
      wb_d     = (rd_q != 5'd0);
      retire_d = 1'b1;
    end

    // Accepting in WRITE overrides the return to IDLE, giving one writeback per cycle.
    if (accept) begin
      rd_d      = in_rd;
      funct3_d  = in_funct3;
      addr_lo_d = in_addr_lo;
      case (in_kind)
        KIND_ALU: begin
          state_d  = WRITE;
          rddata_d = in_result;
          rdsel_d  = in_rd;
          wb_d     = (in_rd != 5'd0);
          retire_d = 1'b1;
        end
        KIND_LOAD: begin
          if (load_legal) begin
            state_d = WAIT_MEM;
          end else begin
            state_d  = IDLE;
            fault_d  = 1'b1;
            retire_d = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          retire_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      rddata_q  <= '0;
      rdsel_q   <= 5'd0;
      wb_q      <= 1'b0;
      retire_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      rddata_q  <= rddata_d;
      rdsel_q   <= rdsel_d;
      wb_q      <= wb_d;
      retire_q  <= retire_d;
      fault_q   <= fault_d;
    end
  end

  assign rddata          = rddata_q;
  assign rdsel           = rdsel_q;
  assign phase_writeback = wb_q;
  assign retire          = retire_q;
  assign load_fault      = fault_q;
  assign pending_rd      = rd_q;
  assign pending_valid   = ((state_q == WAIT_MEM) || (state_q == WRITE)) && (rd_q != 5'd0);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level reference model.
module tb_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] rddata;
  logic [4:0]  rdsel;
  logic        phase_writeback;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        retire;
  logic        load_fault;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the stage should be showing after each edge.
  bit          m_waiting;
  bit          m_writing;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_addr;
  logic [31:0] m_rddata;
  logic [4:0]  m_rdsel;
  bit          m_wb;
  bit          m_retire;
  bit          m_fault;

  writeback_unit #(.XLEN(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_kind(in_kind),
    .in_rd(in_rd),
    .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo),
    .in_result(in_result),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .rddata(rddata),
    .rdsel(rdsel),
    .phase_writeback(phase_writeback),
    .pending_valid(pending_valid),
    .pending_rd(pending_rd),
    .retire(retire),
    .load_fault(load_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit load_ok(input logic [2:0] f3, input logic [1:0] a);
    bit known;
    known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return known && ((int'(a) % access_bytes(f3)) == 0);
  endfunction

  // Arithmetic formulation: shift, take modulo 2^bits, then subtract 2^bits if signed and negative.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    longint v;
    longint span;
    int bits;
    bits = 8 * access_bytes(f3);
    span = longint'(1) << bits;
    v = longint'(w >> (8 * int'(a))) % span;
    if (!f3[2] && bits < 32 && v >= (span / 2)) v = v - span;
    return v[31:0];
  endfunction

  task automatic model_update();
    bit ready;
    if (rst_n) begin
      m_waiting = 0; m_writing = 0; m_rd = 0; m_f3 = 0; m_addr = 0;
      m_rddata = 0; m_rdsel = 0; m_wb = 0; m_retire = 0; m_fault = 0;
      return;
    end
    ready = !m_waiting;
    m_wb = 0; m_retire = 0; m_fault = 0; m_writing = 0;
    if (m_waiting && mem_rvalid) begin
      m_rddata = load_value(m_f3, m_addr, mem_rdata);
      m_rdsel = m_rd;
      m_wb = (m_rd != 0);
      m_retire = 1;
      m_writing = 1;
      m_waiting = 0;
    end else if (ready && in_valid) begin
      m_rd = in_rd; m_f3 = in_funct3; m_addr = in_addr_lo;
      if (in_kind == 2'b00) begin
        m_rddata = in_result; m_rdsel = in_rd; m_wb = (in_rd != 0);
        m_retire = 1; m_writing = 1;
      end else if (in_kind == 2'b01) begin
        if (load_ok(in_funct3, in_addr_lo)) m_waiting = 1;
        else begin m_fault = 1; m_retire = 1; end
      end else begin
        m_retire = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkAllOutputs();
    checkOutput("in_ready", 32'(in_ready), 32'(!m_waiting));
    checkOutput("rddata", rddata, m_rddata);
    checkOutput("rdsel", 32'(rdsel), 32'(m_rdsel));
    checkOutput("phase_writeback", 32'(phase_writeback), 32'(m_wb));
    checkOutput("pending_valid", 32'(pending_valid), 32'((m_waiting || m_writing) && m_rd != 0));
    checkOutput("pending_rd", 32'(pending_rd), 32'(m_rd));
    checkOutput("retire", 32'(retire), 32'(m_retire));
    checkOutput("load_fault", 32'(load_fault), 32'(m_fault));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] kind, input logic [4:0] rd,
                               input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res,
                               input bit mv, input logic [31:0] md);
    rst_n = r; in_valid = v; in_kind = kind; in_rd = rd; in_funct3 = f3;
    in_addr_lo = a; in_result = res; mem_rvalid = mv; mem_rdata = md;
    @(posedge clk);
    model_update();
    #1;
    checkAllOutputs();
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 0, 2'b10, 5'd0, 3'd0, 2'd0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    // Reset
    applyStimulus(1, 0, 2'b00, 5'd0, 3'd0, 2'd0, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 2'b00, 5'd0, 3'd0, 2'd0, 32'h0, 0, 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_rddata", rddata, 32'h0);
    idle_cycle();

    // ALU rd=5
    applyStimulus(0, 1, 2'b00, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 0, 32'h0);
    checkOutput("alu_wb", 32'(phase_writeback), 32'd1);
    checkOutput("alu_rdsel", 32'(rdsel), 32'd5);
    checkOutput("alu_rddata", rddata, 32'h1234_5678);
    checkOutput("alu_retire", 32'(retire), 32'd1);
    idle_cycle();

    // LB addr_lo=3, data after 3 wait cycles
    applyStimulus(0, 1, 2'b01, 5'd9, 3'b000, 2'd3, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 2'b00, 5'd4, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 32'h0);
      checkOutput("lb_wait_ready", 32'(in_ready), 32'd0);
      checkOutput("lb_wait_pending", 32'(pending_valid), 32'd1);
      checkOutput("lb_wait_rd", 32'(pending_rd), 32'd9);
    end
    applyStimulus(0, 0, 2'b00, 5'd0, 3'd0, 2'd0, 32'h0, 1, 32'h80AA_BBCC);
    checkOutput("lb_rddata", rddata, 32'hFFFF_FF80);
    checkOutput("lb_wb", 32'(phase_writeback), 32'd1);
    idle_cycle();

    // LHU addr_lo=2; rvalid on the entry edge must be ignored
    applyStimulus(0, 1, 2'b01, 5'd10, 3'b101, 2'd2, 32'h0, 1, 32'h1111_1111);
    applyStimulus(0, 0, 2'b00, 5'd0, 3'd0, 2'd0, 32'h0, 1, 32'h8001_7FFF);
    checkOutput("lhu_rddata", rddata, 32'h0000_8001);
    idle_cycle();

    // LW misaligned
    applyStimulus(0, 1, 2'b01, 5'd11, 3'b010, 2'd1, 32'h0, 0, 32'h0);
    checkOutput("lw_fault", 32'(load_fault), 32'd1);
    checkOutput("lw_fault_wb", 32'(phase_writeback), 32'd0);
    idle_cycle();

    // Back-to-back ALU to x1, x2, x0
    applyStimulus(0, 1, 2'b00, 5'd1, 3'd0, 2'd0, 32'hA1, 0, 32'h0);
    checkOutput("b2b_wb1", 32'(phase_writeback), 32'd1);
    applyStimulus(0, 1, 2'b00, 5'd2, 3'd0, 2'd0, 32'hB2, 0, 32'h0);
    checkOutput("b2b_wb2", 32'(phase_writeback), 32'd1);
    applyStimulus(0, 1, 2'b00, 5'd0, 3'd0, 2'd0, 32'hC3, 0, 32'h0);
    checkOutput("b2b_wb0", 32'(phase_writeback), 32'd0);
    checkOutput("b2b_retire0", 32'(retire), 32'd1);
    idle_cycle();

    // Reset while waiting on a load, then stale rvalid
    applyStimulus(0, 1, 2'b01, 5'd12, 3'b010, 2'd0, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 2'b00, 5'd0, 3'd0, 2'd0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 2'b00, 5'd0, 3'd0, 2'd0, 32'h0, 1, 32'h5555_AAAA);
    checkOutput("rst_load_wb", 32'(phase_writeback), 32'd0);
    checkOutput("rst_load_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_load_rddata", rddata, 32'h0);

    // Store rd=7
    applyStimulus(0, 1, 2'b10, 5'd7, 3'd0, 2'd0, 32'h77, 0, 32'h0);
    checkOutput("store_retire", 32'(retire), 32'd1);
    checkOutput("store_pending", 32'(pending_valid), 32'd0);
    idle_cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    2'($urandom),
                    ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                    3'($urandom),
                    2'($urandom),
                    $urandom,
                    ($urandom_range(0, 2) == 0),
                    $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
